// File: rtl/sb_master_port.sv
`default_nettype none
// ============================================================================
// Module      : sb_master_port
// Description : Single-outstanding request/response client to sb bus master
//               bridge with registered bus outputs and a wait-cycle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_master_port #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sb_arvalid,
  input  logic        sb_arready,
  output logic [31:0] sb_araddr,
  input  logic        sb_rvalid,
  output logic        sb_rready,
  input  logic [31:0] sb_rdata,
  output logic        sb_wvalid,
  input  logic        sb_wready,
  output logic [31:0] sb_waddr,
  output logic [31:0] sb_wdata,
  output logic [3:0]  sb_wstrb,
  input  logic        sb_bvalid,
  output logic        sb_bready,
  input  logic        sb_bresp
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_RSP  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        arvalid_q, rready_q, wvalid_q, bready_q;
  logic [31:0] araddr_q, waddr_q, wdata_out_q;
  logic [3:0]  wstrb_out_q;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = req_we ? S_W : S_AR;
        end
      end
      S_AR: begin
        if (sb_arready) begin
          cnt_d   = 16'h0;
          state_d = S_R;
        end
      end
      S_R: begin
        // A valid in the final wait cycle wins over the timeout.
        if (sb_rvalid) begin
          rdata_d = sb_rdata;
          err_d   = 1'b0;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= C_TIMEOUT) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = S_RSP;
          end
        end
      end
      S_W: begin
        if (sb_wready) begin
          cnt_d   = 16'h0;
          state_d = S_B;
        end
      end
      S_B: begin
        if (sb_bvalid) begin
          rdata_d = 32'h0;
          err_d   = sb_bresp;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= C_TIMEOUT) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = S_RSP;
          end
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      cnt_q       <= 16'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= 32'h0;
      rready_q    <= 1'b0;
      wvalid_q    <= 1'b0;
      waddr_q     <= 32'h0;
      wdata_out_q <= 32'h0;
      wstrb_out_q <= 4'h0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_RSP);
      arvalid_q   <= (state_d == S_AR);
      araddr_q    <= (state_d == S_AR) ? addr_d : 32'h0;
      rready_q    <= (state_d == S_R);
      wvalid_q    <= (state_d == S_W);
      waddr_q     <= (state_d == S_W) ? addr_d : 32'h0;
      wdata_out_q <= (state_d == S_W) ? wdata_d : 32'h0;
      wstrb_out_q <= (state_d == S_W) ? wstrb_d : 4'h0;
      bready_q    <= (state_d == S_B);
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign sb_arvalid = arvalid_q;
  assign sb_araddr  = araddr_q;
  assign sb_rready  = rready_q;
  assign sb_wvalid  = wvalid_q;
  assign sb_waddr   = waddr_q;
  assign sb_wdata   = wdata_out_q;
  assign sb_wstrb   = wstrb_out_q;
  assign sb_bready  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_master_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_master_port
// Description : Directed vector bench for sb_master_port with a scripted slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_master_port;

  localparam int C_NEVER = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        sb_arvalid, sb_arready, sb_rvalid, sb_rready;
  logic [31:0] sb_araddr, sb_rdata;
  logic        sb_wvalid, sb_wready, sb_bvalid, sb_bready, sb_bresp;
  logic [31:0] sb_waddr, sb_wdata;
  logic [3:0]  sb_wstrb;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  sb_master_port #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sb_arvalid(sb_arvalid), .sb_arready(sb_arready), .sb_araddr(sb_araddr),
    .sb_rvalid(sb_rvalid), .sb_rready(sb_rready), .sb_rdata(sb_rdata),
    .sb_wvalid(sb_wvalid), .sb_wready(sb_wready), .sb_waddr(sb_waddr),
    .sb_wdata(sb_wdata), .sb_wstrb(sb_wstrb),
    .sb_bvalid(sb_bvalid), .sb_bready(sb_bready), .sb_bresp(sb_bresp)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] sdata;
    logic        bresp;
    int          arw, rw, ww, bw, rspw;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one transaction and plays the slave.
  task automatic run_vec(input int i);
    vec_t        v;
    int          cyc, lat, arc, rc, wc, bc;
    logic        bad_req, bad_zero, bad_pay, bad_hold;
    logic [31:0] r0;
    logic        e0;
    v = vecs[i];
    cyc = 0; lat = 0; arc = 0; rc = 0; wc = 0; bc = 0;
    bad_req = 0; bad_zero = 0; bad_pay = 0; bad_hold = 0;
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    req_valid = 1'b1;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    chk($sformatf("v%0d accept", i), {31'b0, req_ready}, 32'd1);
    while (lat == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (req_ready) bad_req = 1;
      if (!sb_arvalid && sb_araddr != 0) bad_zero = 1;
      if (!sb_wvalid && (sb_waddr != 0 || sb_wdata != 0 || sb_wstrb != 0)) bad_zero = 1;
      if (sb_arvalid) begin
        arc++;
        if (sb_araddr != v.addr) bad_pay = 1;
      end
      sb_arready = sb_arvalid && (arc == v.arw + 1);
      if (sb_rready) begin
        rc++;
        sb_rvalid = (rc == v.rw + 1);
        sb_rdata  = sb_rvalid ? v.sdata : 32'h0;
      end else begin
        sb_rvalid = v.we;
        sb_rdata  = 32'hBAD0BAD0;
      end
      if (sb_wvalid) begin
        wc++;
        if (sb_waddr != v.addr || sb_wdata != v.wdata || sb_wstrb != v.wstrb) bad_pay = 1;
      end
      sb_wready = sb_wvalid && (wc == v.ww + 1);
      if (sb_bready) begin
        bc++;
        sb_bvalid = (bc == v.bw + 1);
        sb_bresp  = sb_bvalid ? v.bresp : 1'b0;
      end else begin
        sb_bvalid = !v.we;
        sb_bresp  = 1'b1;
      end
      if (rsp_valid) lat = cyc;
    end
    chk($sformatf("v%0d latency", i), lat, v.exp_lat);
    chk($sformatf("v%0d rdata", i), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d err", i), {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d ar cycles", i), arc, v.we ? 0 : v.arw + 1);
    chk($sformatf("v%0d w cycles", i), wc, v.we ? v.ww + 1 : 0);
    r0 = rsp_rdata; e0 = rsp_err;
    for (int k = 0; k < v.rspw; k++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      if (!rsp_valid || rsp_rdata != r0 || rsp_err != e0 || req_ready) bad_hold = 1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp dropped", i), {31'b0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d req_ready back", i), {31'b0, req_ready}, 32'd1);
    chk($sformatf("v%0d flags req/zero/pay/hold", i),
        {28'b0, bad_req, bad_zero, bad_pay, bad_hold}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we   addr          wdata         strb   sdata         bresp arw rw       ww bw       rspw lat rdata         err
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0, 0,       0, 0,       0,   3, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h2000_0000, 32'h1234_5678, 4'h3, 32'h0,       1'b0, 0, 0,       4, 0,       0,   7, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 32'h0,       1'b1, 0, 0,       0, 2,       0,   5, 32'h0,        1'b1};
    vecs[3] = '{1'b0, 32'h0000_0080, 32'h0,        4'h0, 32'h5555_5555, 1'b0, 0, C_NEVER, 0, 0,       0,  10, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 32'h0000_0084, 32'h0,        4'h0, 32'hCAFE_F00D, 1'b0, 0, 7,       0, 0,       0,  10, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 32'h0123_4567, 1'b0, 2, 1,       0, 0,       6,   6, 32'h0123_4567, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0200, 32'hFFFF_0000, 4'h5, 32'h0,       1'b0, 0, 0,       0, C_NEVER, 0,  10, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 32'h0000_0204, 32'h0BAD_F00D, 4'h8, 32'h0,       1'b0, 0, 0,       1, 7,       0,  11, 32'h0,        1'b0};

    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 0; sb_arready = 0; sb_rvalid = 0; sb_rdata = 0;
    sb_wready = 0; sb_bvalid = 0; sb_bresp = 0;
    #1;
    chk("reset valids", {26'b0, req_ready, rsp_valid, sb_arvalid, sb_rready, sb_wvalid, sb_bready}, 32'd0);
    chk("reset addr/data", sb_araddr | sb_waddr | sb_wdata | {28'b0, sb_wstrb} | rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready after reset", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset asserted while the read address phase is stalled.
    req_we = 1'b0; req_addr = 32'h0000_0300; req_valid = 1'b1; sb_arready = 1'b0;
    chk("rst seq accept", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst seq in AR", {31'b0, sb_arvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async arvalid clear", {30'b0, sb_arvalid, req_ready}, 32'd0);
    chk("async araddr clear", sb_araddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_ready before edge", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("req_ready first edge", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    run_vec(5);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
